// File: rtl/display_pkg.sv
// Shared seven-segment definitions: segment bit positions, hex glyph table
// and a helper for sizing prescaler counters.
`default_nettype none

package display_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Index 15 first: entry n lights the glyph for hex digit n (gfedcba, active-high).
  localparam seg_t [15:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Counter width for a 0..div-1 prescaler; a divide of 1 still needs one bit.
  function automatic int unsigned div_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_segment_decoder.sv
// Purely combinational hex digit to seven-segment pattern lookup.
`default_nettype none

module seven_segment_decoder
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = SEG_TABLE[hex];

endmodule

`default_nettype wire

// File: rtl/display_test.sv
// Two-digit multiplexed hex counter: a slow prescaler steps an 8-bit value and a
// fast prescaler alternates the display select between its high and low nibble.
`default_nettype none

module display_test
  import display_pkg::*;
#(
  parameter int unsigned MUX_DIV   = 12000,
  parameter int unsigned COUNT_DIV = 12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [6:0] led_port,
  output logic       c
);

  localparam int unsigned MUX_W = div_width(MUX_DIV);
  localparam int unsigned CNT_W = div_width(COUNT_DIV);
  localparam logic [MUX_W-1:0] MUX_LAST = MUX_W'(MUX_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_DIV - 1);

  logic [MUX_W-1:0] mux_cnt, mux_cnt_next;
  logic [CNT_W-1:0] cnt_pre, cnt_pre_next;
  logic [7:0]       value, value_next;
  logic             c_next;
  logic             mux_wrap, cnt_wrap;
  logic [3:0]       nibble_next;
  seg_t             seg_next;

  always_comb begin
    mux_wrap     = (mux_cnt == MUX_LAST);
    cnt_wrap     = (cnt_pre == CNT_LAST);
    mux_cnt_next = mux_wrap ? '0 : mux_cnt + MUX_W'(1);
    cnt_pre_next = cnt_wrap ? '0 : cnt_pre + CNT_W'(1);
    c_next       = c ^ mux_wrap;
    value_next   = value + {7'd0, cnt_wrap};
    // Decode from next-state select/value so all outputs move on the same edge.
    nibble_next  = c_next ? value_next[7:4] : value_next[3:0];
  end

  seven_segment_decoder u_decoder (
    .hex (nibble_next),
    .seg (seg_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mux_cnt  <= '0;
      cnt_pre  <= '0;
      value    <= 8'h00;
      c        <= 1'b1;
      led_port <= SEG_TABLE[0];
    end else begin
      mux_cnt  <= mux_cnt_next;
      cnt_pre  <= cnt_pre_next;
      value    <= value_next;
      c        <= c_next;
      led_port <= seg_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_test.sv
// Randomised-reset bench: three display_test instances and one decoder checked
// every cycle against an edge-count arithmetic model, plus pinned literal points.
`default_nettype none

module tb_display_test;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] led_a, led_b, led_c;
  logic       c_a, c_b, c_c;
  logic [3:0] dec_in;
  logic [6:0] dec_out;

  int unsigned k = 0;          // rising edges since rst_n last seen low
  logic        seen_rst = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  display_test #(.MUX_DIV(4), .COUNT_DIV(10)) u_a (
    .clk(clk), .rst_n(rst_n), .led_port(led_a), .c(c_a));
  display_test #(.MUX_DIV(5), .COUNT_DIV(10)) u_b (
    .clk(clk), .rst_n(rst_n), .led_port(led_b), .c(c_b));
  display_test #(.MUX_DIV(1), .COUNT_DIV(1)) u_c (
    .clk(clk), .rst_n(rst_n), .led_port(led_c), .c(c_c));
  seven_segment_decoder u_dec (.hex(dec_in), .seg(dec_out));

  assign dec_in = 4'(k);

  always @(posedge clk) begin
    k <= rst_n ? k + 1 : 0;
    if (!rst_n) seen_rst <= 1'b1;
  end

  // After n edges since reset: c has toggled n/mux times starting from 1,
  // and the value has advanced n/cnt times modulo 256.
  function automatic logic exp_c(input int unsigned n, input int unsigned mux);
    return ((n / mux) % 2) == 0;
  endfunction

  function automatic logic [6:0] exp_led(input int unsigned n, input int unsigned mux,
                                         input int unsigned cnt);
    int unsigned v;
    v = (n / cnt) % 256;
    return exp_c(n, mux) ? glyph[v / 16] : glyph[v % 16];
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (seen_rst) begin
      check("c_a",   7'(c_a), 7'(exp_c(k, 4)));
      check("led_a", led_a,   exp_led(k, 4, 10));
      check("c_b",   7'(c_b), 7'(exp_c(k, 5)));
      check("led_b", led_b,   exp_led(k, 5, 10));
      check("c_c",   7'(c_c), 7'(exp_c(k, 1)));
      check("led_c", led_c,   exp_led(k, 1, 1));
      check("dec",   dec_out, glyph[dec_in]);
      case (k)
        0:    begin check("pin_rst_c", 7'(c_a), 7'h01); check("pin_rst_led", led_a, 7'h3F); end
        3:    begin check("pin_e3_c", 7'(c_a), 7'h01); check("pin_c3_led", led_c, 7'h4F); end
        4:    begin check("pin_e4_c", 7'(c_a), 7'h00); check("pin_e4_led", led_a, 7'h3F); end
        10:   begin check("pin_e10_led", led_a, 7'h3F); check("pin_b10_c", 7'(c_b), 7'h01);
                    check("pin_b10_led", led_b, 7'h3F); end
        12:   check("pin_e12_led", led_a, 7'h06);
        15:   begin check("pin_b15_c", 7'(c_b), 7'h00); check("pin_b15_led", led_b, 7'h06); end
        16:   check("pin_c16_led", led_c, 7'h06);
        170:  check("pin_e170_led", led_a, 7'h06);
        172:  check("pin_e172_led", led_a, 7'h06);
        2552: check("pin_ff_hi", led_a, 7'h71);
        2559: check("pin_ff_lo", led_a, 7'h71);
        2560: begin check("pin_wrap_c", 7'(c_a), 7'h01); check("pin_wrap_hi", led_a, 7'h3F); end
        2564: check("pin_wrap_lo", led_a, 7'h3F);
        default: ;
      endcase
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2600) @(negedge clk);
    // Reset landing exactly on the edge where instance A's increment is due.
    for (int i = 0; i < 20 && k != 9; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 70)) @(negedge clk);
      rst_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (50) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
